axistream_snooper: RTL and testbench

//  Passive tap on an AXI-Stream link that copies each packet into a free packet-filter buffer.

---
 rtl/axistream_snooper_pkg.sv | 23 ++
 rtl/axistream_snooper_outreg.sv | 42 ++++
 rtl/axistream_snooper.sv | 152 +++++++++++++++
 tb/tb_axistream_snooper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axistream_snooper_pkg.sv
// Shared types and helpers for the AXI-Stream snooper.
package axistream_snooper_pkg;

    // Widest TKEEP the popcount helper handles (512-bit TDATA).
    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        ST_SOP     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DROP    = 2'd2
    } sn_state_t;

    // Number of set bits in a (zero-extended) byte-enable vector.
    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/axistream_snooper_outreg.sv
// Delay line for the buffer-write bundle: one register stage, or two when PESS is set.
module axistream_snooper_outreg #(
    parameter int W    = 8,
    parameter int PESS = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage1_r;

    // First output stage, always present.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_r <= '0;
        end else begin
            stage1_r <= d;
        end
    end

    generate
        if (PESS != 0) begin : g_pess
            logic [W-1:0] stage2_r;

            // Extra stage for timing-pessimistic builds.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage2_r <= '0;
                end else begin
                    stage2_r <= stage1_r;
                end
            end

            assign q = stage2_r;
        end else begin : g_fast
            assign q = stage1_r;
        end
    endgenerate

endmodule

// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap: copies each packet into a free filter buffer or drops it.
module axistream_snooper
    import axistream_snooper_pkg::*;
#(
    parameter int SN_FWD_DATA_WIDTH   = 64,
    parameter int SN_FWD_ADDR_WIDTH   = 9,
    parameter int SN_INC_WIDTH        = 3,
    parameter int PESS                = 0,
    parameter int ENABLE_BACKPRESSURE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SN_FWD_DATA_WIDTH-1:0]   sn_TDATA,
    input  logic [SN_FWD_DATA_WIDTH/8-1:0] sn_TKEEP,
    input  logic                           sn_TREADY,
    output logic                           sn_bp_TREADY,
    input  logic                           sn_TVALID,
    input  logic                           sn_TLAST,
    output logic [SN_FWD_ADDR_WIDTH-1:0]   sn_addr,
    output logic [SN_FWD_DATA_WIDTH-1:0]   sn_wr_data,
    output logic                           sn_wr_en,
    output logic [SN_INC_WIDTH-1:0]        sn_byte_inc,
    output logic                           sn_done,
    input  logic                           rdy_for_sn,
    output logic                           rdy_for_sn_ack,
    output logic                           packet_dropped_inc
);

    localparam int DW = SN_FWD_DATA_WIDTH;
    localparam int AW = SN_FWD_ADDR_WIDTH;
    localparam int IW = SN_INC_WIDTH;
    localparam int BW = 2 + IW + AW + DW;

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    sn_state_t     state_r;
    sn_state_t     state_nxt_s;
    logic          at_sop_r;
    logic [AW-1:0] addr_cnt_r;
    logic [AW-1:0] addr_cnt_nxt_s;
    logic          beat_s;

    logic          wr_en_s;
    logic          done_s;
    logic [AW-1:0] wr_addr_s;
    logic [7:0]    popcnt_s;
    logic [IW-1:0] byte_inc_s;
    logic [BW-1:0] bundle_s;
    logic [BW-1:0] bundle_q_s;

    // Upstream ready: optionally hold off a new packet until a buffer is free.
    always_comb begin
        if (ENABLE_BACKPRESSURE != 0) begin
            sn_bp_TREADY = sn_TREADY & ~(at_sop_r & ~rdy_for_sn);
        end else begin
            sn_bp_TREADY = sn_TREADY;
        end
    end

    assign beat_s     = sn_TVALID & sn_bp_TREADY;
    assign popcnt_s   = popcount(KEEP_MAX'(sn_TKEEP));
    assign byte_inc_s = popcnt_s[IW-1:0];

    // Next-state, address and write-strobe decode for the capture FSM.
    always_comb begin
        state_nxt_s        = state_r;
        addr_cnt_nxt_s     = addr_cnt_r;
        wr_en_s            = 1'b0;
        done_s             = 1'b0;
        wr_addr_s          = '0;
        rdy_for_sn_ack     = 1'b0;
        packet_dropped_inc = 1'b0;
        case (state_r)
            ST_SOP: begin
                if (beat_s) begin
                    if (rdy_for_sn) begin
                        rdy_for_sn_ack = 1'b1;
                        wr_en_s        = 1'b1;
                        wr_addr_s      = '0;
                        addr_cnt_nxt_s = '0;
                        done_s         = sn_TLAST;
                        state_nxt_s    = sn_TLAST ? ST_SOP : ST_CAPTURE;
                    end else begin
                        packet_dropped_inc = 1'b1;
                        state_nxt_s        = sn_TLAST ? ST_SOP : ST_DROP;
                    end
                end else begin
                    state_nxt_s = ST_SOP;
                end
            end
            ST_CAPTURE: begin
                if (beat_s) begin
                    // Saturate at the last buffer word; later beats are not stored.
                    if (addr_cnt_r != ADDR_MAX) begin
                        wr_en_s        = 1'b1;
                        wr_addr_s      = addr_cnt_r + ADDR_ONE;
                        addr_cnt_nxt_s = addr_cnt_r + ADDR_ONE;
                    end else begin
                        wr_addr_s = addr_cnt_r;
                    end
                    done_s      = sn_TLAST;
                    state_nxt_s = sn_TLAST ? ST_SOP : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DROP: begin
                if (beat_s && sn_TLAST) begin
                    state_nxt_s = ST_SOP;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_SOP;
            end
        endcase
    end

    // FSM state, address counter and start-of-packet tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_SOP;
            addr_cnt_r <= '0;
            at_sop_r   <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            addr_cnt_r <= addr_cnt_nxt_s;
            if (beat_s) begin
                at_sop_r <= sn_TLAST;
            end else begin
                at_sop_r <= at_sop_r;
            end
        end
    end

    assign bundle_s = {done_s, wr_en_s, byte_inc_s, wr_addr_s, sn_TDATA};

    axistream_snooper_outreg #(
        .W    (BW),
        .PESS (PESS)
    ) u_outreg (
        .clk (clk),
        .rst (rst),
        .d   (bundle_s),
        .q   (bundle_q_s)
    );

    assign {sn_done, sn_wr_en, sn_byte_inc, sn_addr, sn_wr_data} = bundle_q_s;

endmodule

// File: tb/tb_axistream_snooper.sv
// Directed self-checking bench for axistream_snooper (drop and backpressure builds).
module tb_axistream_snooper;

    logic        clk;
    logic        rst;

    // Drop-mode instance signals
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        trdy;
    logic        bp_trdy;
    logic        tvalid;
    logic        tlast;
    logic [8:0]  addr;
    logic [63:0] wr_data;
    logic        wr_en;
    logic [2:0]  byte_inc;
    logic        done;
    logic        rdy;
    logic        ack;
    logic        drop;

    // Backpressure instance signals
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
    logic        b_trdy;
    logic        b_bp_trdy;
    logic        b_tvalid;
    logic        b_tlast;
    logic [8:0]  b_addr;
    logic [63:0] b_wr_data;
    logic        b_wr_en;
    logic [2:0]  b_byte_inc;
    logic        b_done;
    logic        b_rdy;
    logic        b_ack;
    logic        b_drop;

    int checks;
    int failures;

    axistream_snooper #(
        .SN_FWD_DATA_WIDTH(64), .SN_FWD_ADDR_WIDTH(9), .SN_INC_WIDTH(3),
        .PESS(0), .ENABLE_BACKPRESSURE(0)
    ) dut (
        .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep),
        .sn_TREADY(trdy), .sn_bp_TREADY(bp_trdy), .sn_TVALID(tvalid),
        .sn_TLAST(tlast), .sn_addr(addr), .sn_wr_data(wr_data),
        .sn_wr_en(wr_en), .sn_byte_inc(byte_inc), .sn_done(done),
        .rdy_for_sn(rdy), .rdy_for_sn_ack(ack), .packet_dropped_inc(drop)
    );

    axistream_snooper #(
        .SN_FWD_DATA_WIDTH(64), .SN_FWD_ADDR_WIDTH(9), .SN_INC_WIDTH(3),
        .PESS(0), .ENABLE_BACKPRESSURE(1)
    ) dut_bp (
        .clk(clk), .rst(rst), .sn_TDATA(b_tdata), .sn_TKEEP(b_tkeep),
        .sn_TREADY(b_trdy), .sn_bp_TREADY(b_bp_trdy), .sn_TVALID(b_tvalid),
        .sn_TLAST(b_tlast), .sn_addr(b_addr), .sn_wr_data(b_wr_data),
        .sn_wr_en(b_wr_en), .sn_byte_inc(b_byte_inc), .sn_done(b_done),
        .rdy_for_sn(b_rdy), .rdy_for_sn_ack(b_ack), .packet_dropped_inc(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the drop-mode instance: apply inputs, check the
    // combinational pulses, then check the registered write bundle.
    task automatic cyc(input string tag, input bit v, input bit l, input logic [7:0] k,
                       input logic [63:0] d, input bit e_ack, input bit e_drop,
                       input bit e_we, input logic [8:0] e_addr, input logic [2:0] e_inc,
                       input bit e_done);
        tvalid = v; tlast = l; tkeep = k; tdata = d;
        #1;
        check_val({tag, ".ack"}, {63'd0, ack}, {63'd0, e_ack});
        check_val({tag, ".drop"}, {63'd0, drop}, {63'd0, e_drop});
        @(posedge clk);
        #1;
        check_val({tag, ".wr_en"}, {63'd0, wr_en}, {63'd0, e_we});
        check_val({tag, ".done"}, {63'd0, done}, {63'd0, e_done});
        if (e_we) begin
            check_val({tag, ".addr"}, {55'd0, addr}, {55'd0, e_addr});
            check_val({tag, ".data"}, wr_data, d);
            check_val({tag, ".inc"}, {61'd0, byte_inc}, {61'd0, e_inc});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        tdata = 64'd0; tkeep = 8'd0; trdy = 1'b1; tvalid = 1'b0; tlast = 1'b0; rdy = 1'b0;
        b_tdata = 64'd0; b_tkeep = 8'd0; b_trdy = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0; b_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_val("rst.wr_en", {63'd0, wr_en}, 64'd0);
        check_val("rst.addr", {55'd0, addr}, 64'd0);
        check_val("rst.done", {63'd0, done}, 64'd0);
        check_val("rst.bp_trdy", {63'd0, bp_trdy}, 64'd1);
        check_val("rst.b_wr_en", {63'd0, b_wr_en}, 64'd0);

        // 1: three-beat capture
        rdy = 1'b1;
        cyc("t1.b1", 1'b1, 1'b0, 8'hFF, 64'hA1A1_0000_0000_0001, 1'b1, 1'b0, 1'b1, 9'd0, 3'd0, 1'b0);
        cyc("t1.b2", 1'b1, 1'b0, 8'hFF, 64'hA1A1_0000_0000_0002, 1'b0, 1'b0, 1'b1, 9'd1, 3'd0, 1'b0);
        cyc("t1.b3", 1'b1, 1'b1, 8'h0F, 64'hA1A1_0000_0000_0003, 1'b0, 1'b0, 1'b1, 9'd2, 3'd4, 1'b1);
        cyc("t1.idle", 1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 1'b0);

        // 2: dropped packet, then capture from 0
        rdy = 1'b0;
        cyc("t2.d1", 1'b1, 1'b0, 8'hFF, 64'hB2B2_0000_0000_0001, 1'b0, 1'b1, 1'b0, 9'd0, 3'd0, 1'b0);
        cyc("t2.d2", 1'b1, 1'b1, 8'hFF, 64'hB2B2_0000_0000_0002, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 1'b0);
        rdy = 1'b1;
        cyc("t2.c1", 1'b1, 1'b0, 8'hFF, 64'hB2B2_0000_0000_0003, 1'b1, 1'b0, 1'b1, 9'd0, 3'd0, 1'b0);
        cyc("t2.c2", 1'b1, 1'b1, 8'h01, 64'hB2B2_0000_0000_0004, 1'b0, 1'b0, 1'b1, 9'd1, 3'd1, 1'b1);

        // 4: TVALID gap and TREADY stall inside a packet
        cyc("t4.b1", 1'b1, 1'b0, 8'hFF, 64'hC4C4_0000_0000_0001, 1'b1, 1'b0, 1'b1, 9'd0, 3'd0, 1'b0);
        cyc("t4.gap", 1'b0, 1'b0, 8'hFF, 64'hC4C4_0000_0000_00EE, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 1'b0);
        cyc("t4.b2", 1'b1, 1'b0, 8'h3F, 64'hC4C4_0000_0000_0002, 1'b0, 1'b0, 1'b1, 9'd1, 3'd6, 1'b0);
        trdy = 1'b0;
        cyc("t4.stall", 1'b1, 1'b1, 8'h07, 64'hC4C4_0000_0000_0003, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 1'b0);
        check_val("t4.bp_follows", {63'd0, bp_trdy}, 64'd0);
        trdy = 1'b1;
        cyc("t4.b3", 1'b1, 1'b1, 8'h07, 64'hC4C4_0000_0000_0003, 1'b0, 1'b0, 1'b1, 9'd2, 3'd3, 1'b1);

        // 5: single-beat packet
        cyc("t5.b1", 1'b1, 1'b1, 8'h7F, 64'hD5D5_0000_0000_0001, 1'b1, 1'b0, 1'b1, 9'd0, 3'd7, 1'b1);

        // Reset mid-packet: remaining beats start a new packet
        cyc("rm.b1", 1'b1, 1'b0, 8'hFF, 64'hE0E0_0000_0000_0001, 1'b1, 1'b0, 1'b1, 9'd0, 3'd0, 1'b0);
        cyc("rm.b2", 1'b1, 1'b0, 8'hFF, 64'hE0E0_0000_0000_0002, 1'b0, 1'b0, 1'b1, 9'd1, 3'd0, 1'b0);
        rst = 1'b1;
        cyc("rm.rst", 1'b0, 1'b0, 8'hFF, 64'd0, 1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 1'b0);
        rst = 1'b0;
        cyc("rm.b3", 1'b1, 1'b1, 8'hFF, 64'hE0E0_0000_0000_0003, 1'b1, 1'b0, 1'b1, 9'd0, 3'd0, 1'b1);

        // 6: 520-beat packet saturates at address 511
        for (int i = 0; i < 520; i++) begin
            if (i < 512) begin
                cyc("t6.wr", 1'b1, (i == 519), 8'hFF, 64'hF6F6_0000_0000_0000 + 64'(i),
                    (i == 0), 1'b0, 1'b1, 9'(i), 3'd0, 1'b0);
            end else begin
                cyc("t6.sat", 1'b1, (i == 519), 8'hFF, 64'hF6F6_0000_0000_0000 + 64'(i),
                    1'b0, 1'b0, 1'b0, 9'd0, 3'd0, (i == 519));
            end
        end
        cyc("t6.next", 1'b1, 1'b1, 8'h03, 64'hF6F6_FFFF_0000_0000, 1'b1, 1'b0, 1'b1, 9'd0, 3'd2, 1'b1);
        tvalid = 1'b0;

        // 3: backpressure build holds off the packet instead of dropping it
        b_rdy = 1'b0; b_tvalid = 1'b1; b_trdy = 1'b1; b_tlast = 1'b0;
        b_tkeep = 8'hFF; b_tdata = 64'h3333_0000_0000_0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("t3.hold_trdy", {63'd0, b_bp_trdy}, 64'd0);
            check_val("t3.hold_drop", {63'd0, b_drop}, 64'd0);
            check_val("t3.hold_ack", {63'd0, b_ack}, 64'd0);
            @(posedge clk);
            #1;
            check_val("t3.hold_we", {63'd0, b_wr_en}, 64'd0);
        end
        b_rdy = 1'b1;
        #1;
        check_val("t3.go_trdy", {63'd0, b_bp_trdy}, 64'd1);
        check_val("t3.go_ack", {63'd0, b_ack}, 64'd1);
        @(posedge clk);
        #1;
        check_val("t3.w0_we", {63'd0, b_wr_en}, 64'd1);
        check_val("t3.w0_addr", {55'd0, b_addr}, 64'd0);
        check_val("t3.w0_data", b_wr_data, 64'h3333_0000_0000_0001);
        b_rdy = 1'b0; b_tlast = 1'b1; b_tkeep = 8'h1F; b_tdata = 64'h3333_0000_0000_0002;
        #1;
        check_val("t3.mid_trdy", {63'd0, b_bp_trdy}, 64'd1);
        check_val("t3.mid_ack", {63'd0, b_ack}, 64'd0);
        @(posedge clk);
        #1;
        check_val("t3.w1_we", {63'd0, b_wr_en}, 64'd1);
        check_val("t3.w1_addr", {55'd0, b_addr}, 64'd1);
        check_val("t3.w1_inc", {61'd0, b_byte_inc}, 64'd5);
        check_val("t3.w1_done", {63'd0, b_done}, 64'd1);
        b_tvalid = 1'b0; b_tlast = 1'b0;
        #1;
        check_val("t3.sop_trdy", {63'd0, b_bp_trdy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
